arb_burst_issuer: RTL and testbench
===================================

Name: arb_burst_issuer

Overview:
- Upstream/downstream companion to the 4-way round-robin arbiter.
- Holds one pending burst command per client and drives the arbiter's four request lines.
- Consumes the arbiter's one-hot grant and issues the granted client's burst onto a single shared address bus with a valid/ready handshake.
- Releases the request after the last beat so the arbiter can rotate.

Parameters:
- AW, 16, address width of commands and output bus.
- LENW, 4, burst length field width; beats per burst = len+1 (1..2^LENW).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  4  per-client command valid; bit i = client i.
- cmd_ready  out  4  per-client slot empty; command accepted when valid&ready.
- cmd_addr  in  4*AW  per-client base address; client i at [i*AW +: AW].
- cmd_len  in  4*LENW  per-client burst length minus one.
- req  out  4  to arbiter req3..req0 (bit i = reqi).
- gnt  in  4  from arbiter gnt3..gnt0, expected one-hot or zero.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_addr  out  AW  beat address.
- out_id  out  2  owning client index.
- out_last  out  1  final beat of burst.
- gnt_err  out  1  sticky: multi-hot gnt seen in IDLE.

Behaviour:
- Slots:
  - 4 registered slots (valid, addr, len).
  - cmd_ready[i] = ~slot_valid[i], purely from the register.
  - Accept on cmd_valid[i]&cmd_ready[i]: capture addr/len, set slot_valid[i] next edge.
  - req[i] = slot_valid[i], so req rises the cycle after acceptance.
- FSM states IDLE, XFER, RELEASE.
- IDLE:
  - Candidate set = gnt & slot_valid.
  - If the candidate set is nonzero, pick the lowest set index k, load owner=k, addr_ctr=slot_addr[k], beat_ctr=slot_len[k], and go to XFER. out_valid rises the next cycle.
  - gnt bits for empty slots are ignored; stale grants are expected.
  - If gnt has more than one bit set in IDLE, set gnt_err. It stays set until rst.
- XFER:
  - out_valid=1, out_addr=addr_ctr, out_id=owner, out_last=(beat_ctr==0).
  - Outputs hold stable while out_valid&~out_ready.
  - On a handshake with beat_ctr!=0: addr_ctr+=1, wrapping modulo 2^AW; beat_ctr-=1.
  - On a handshake with out_last: clear slot_valid[owner] and go to RELEASE.
  - gnt is not sampled in XFER; the arbiter holds its grant while req stays high.
- RELEASE:
  - One cycle with out_valid=0.
  - req[owner] is already low, letting the arbiter drop its grant and rotate. Then go to IDLE.
  - cmd_ready[owner] is high from RELEASE onward, so a refill is possible; the refilled slot re-requests.
- Latency:
  - Accept-to-req: 1 cycle.
  - Grant-seen-to-first-beat: 1 cycle.
  - Back-to-back beats at full throughput when out_ready=1.
  - Minimum 2 idle cycles between bursts (RELEASE + IDLE sample).
- Simultaneous events:
  - A new command to a client other than the owner during XFER is accepted normally.
  - A command for the owner client is not accepted until its slot clears.
- Reset values: cmd_ready=4'hF, req=0, out_valid=0, out_last=0, out_addr=0, out_id=0, gnt_err=0, all slots invalid, FSM=IDLE.
- Reset mid-burst: all slots and the burst are discarded; outputs return to reset values at the next edge.

Test Plan:
- Single burst: client0 addr=0x0100 len=3, gnt=0001 one cycle after req[0] -> four beats 0x0100..0x0103, out_id=0, out_last only on 0x0103, req[0] low after last beat, cmd_ready[0] high.
- Backpressure: during a 4-beat burst, hold out_ready=0 for 3 cycles on beat 2 -> out_addr, out_id, out_last stable throughout; no beat lost or duplicated.
- Rotation with the real arbiter: clients 0..3 all loaded with len=1 -> four bursts in arbiter rotation order, each with a RELEASE gap, and every client served exactly once.
- Wrap: addr=0xFFFE len=3 -> beats 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Stale/illegal grant:
  - gnt=0100 with slot2 empty -> no transfer.
  - gnt=0011 with slots 0 and 1 valid -> client0 served, gnt_err=1 and stays set.
- Reset mid-burst: assert rst during beat 1 of len=7 -> next cycle out_valid=0, req=0, cmd_ready=4'hF; a subsequent command is served from its beat 0.

Source files
------------

// File: rtl/arb_burst_issuer.sv
// arb_burst_issuer: holds one burst command per client, requests the arbiter, issues granted bursts beat by beat
module arb_burst_issuer #(
   parameter int AW   = 16,
   parameter int LENW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        cmd_valid,
   output logic [3:0]        cmd_ready,
   input  logic [4*AW-1:0]   cmd_addr,
   input  logic [4*LENW-1:0] cmd_len,
   output logic [3:0]        req,
   input  logic [3:0]        gnt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [AW-1:0]     out_addr,
   output logic [1:0]        out_id,
   output logic              out_last,
   output logic              gnt_err
);
   typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;
   state_t          state, state_n;
   logic [3:0]      slot_valid;
   logic [AW-1:0]   slot_addr [4];
   logic [LENW-1:0] slot_len [4];
   logic [1:0]      owner, pick;
   logic [AW-1:0]   addr_ctr;
   logic [LENW-1:0] beat_ctr;
   logic [3:0]      cand, accept;
   logic            hs, done, start, multi;
   assign cmd_ready = ~slot_valid;
   assign req       = slot_valid;
   assign cand      = gnt & slot_valid;
   assign accept    = cmd_valid & ~slot_valid;
   assign out_valid = state == XFER;
   assign out_addr  = addr_ctr;
   assign out_id    = owner;
   assign out_last  = out_valid && beat_ctr == '0;
   assign hs        = out_valid & out_ready;
   assign done      = hs & out_last;
   assign start     = state == IDLE && cand != 4'd0;
   assign multi     = state == IDLE && (gnt & (gnt - 4'd1)) != 4'd0;
   // lowest granted client with a pending slot wins when the grant is multi-hot
   always_comb begin
      pick = cand[0] ? 2'd0 : cand[1] ? 2'd1 : cand[2] ? 2'd2 : 2'd3;
   end
   // burst sequencing: wait for a usable grant, stream beats, then one release cycle
   always_comb begin
      state_n = state;
      if (start) state_n = XFER;
      else if (state == XFER && done) state_n = RELEASE;
      else if (state == RELEASE) state_n = IDLE;
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   // beat counters, owner latch and sticky multi-grant flag
   always_ff @(posedge clk) begin
      if (rst) begin
         owner    <= '0;
         addr_ctr <= '0;
         beat_ctr <= '0;
         gnt_err  <= 1'b0;
      end else begin
         gnt_err <= gnt_err | multi;
         if (start) begin
            owner    <= pick;
            addr_ctr <= slot_addr[pick];
            beat_ctr <= slot_len[pick];
         end else if (hs && !out_last) begin
            addr_ctr <= addr_ctr + 1'b1;
            beat_ctr <= beat_ctr - 1'b1;
         end
      end
   end
   // per-client slots: fill on accept, empty after the owner's last beat
   always_ff @(posedge clk) begin
      if (rst) slot_valid <= '0;
      else for (int i = 0; i < 4; i++) begin
         if (accept[i]) slot_valid[i] <= 1'b1;
         else if (done && owner == 2'(i)) slot_valid[i] <= 1'b0;
      end
   end
   // slot payload capture, needs no reset since slot_valid qualifies it
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (accept[i]) begin
            slot_addr[i] <= cmd_addr[i*AW +: AW];
            slot_len[i]  <= cmd_len[i*LENW +: LENW];
         end
      end
   end
endmodule

// File: tb/tb_arb_burst_issuer.sv
// tb_arb_burst_issuer: directed bench with a round-robin arbiter model for rotation
module tb_arb_burst_issuer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  cmd_valid = '0;
   logic [3:0]  cmd_ready;
   logic [63:0] cmd_addr = '0;
   logic [15:0] cmd_len = '0;
   logic [3:0]  req;
   logic [3:0]  gnt, gnt_man = '0, arb_gnt;
   logic        use_arb = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_addr;
   logic [1:0]  out_id;
   logic        out_last;
   logic        gnt_err;
   int          total = 0, bad = 0, last_g;

   arb_burst_issuer #(.AW(16), .LENW(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .req(req), .gnt(gnt),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_id(out_id), .out_last(out_last), .gnt_err(gnt_err)
   );

   assign gnt = use_arb ? arb_gnt : gnt_man;

   always #5 clk = ~clk;

   // round-robin arbiter: holds grant while its request stays up, then rotates past the last winner
   always @(posedge clk) begin
      if (rst) begin
         arb_gnt <= '0;
         last_g  <= 3;
      end else if ((arb_gnt & req) == 4'd0) begin
         arb_gnt <= '0;
         for (int i = 4; i >= 1; i--)
            if (req[(last_g + i) % 4]) begin
               arb_gnt <= 4'b1 << ((last_g + i) % 4);
               last_g  <= (last_g + i) % 4;
            end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load(input int c, input logic [15:0] a, input logic [3:0] l);
      cmd_valid = 4'b1 << c;
      cmd_addr[c*16 +: 16] = a;
      cmd_len[c*4 +: 4] = l;
      tick();
      cmd_valid = '0;
   endtask

   task automatic run_burst(input int id, input logic [15:0] a, input int n, input int sb, input int sc);
      int w;
      logic [15:0] ea;
      w = 0;
      while (!out_valid && w < 20) begin
         tick();
         w++;
      end
      chk("burst_start", out_valid, 1);
      for (int b = 0; b < n; b++) begin
         ea = a + 16'(b);
         if (b == sb) begin
            out_ready = 1'b0;
            for (int s = 0; s < sc; s++) begin
               tick();
               chk("stall_valid", out_valid, 1);
               chk("stall_addr", out_addr, ea);
               chk("stall_id", out_id, id);
               chk("stall_last", out_last, b == n - 1);
            end
            out_ready = 1'b1;
         end
         chk("beat_valid", out_valid, 1);
         chk("beat_addr", out_addr, ea);
         chk("beat_id", out_id, id);
         chk("beat_last", out_last, b == n - 1);
         tick();
      end
      chk("release_gap", out_valid, 0);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_cmd_ready", cmd_ready, 4'hF);
      chk("rst_req", req, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_id", out_id, 0);
      chk("rst_err", gnt_err, 0);
      rst = 1'b0;

      load(0, 16'h0100, 4'd3);
      chk("s1_req", req, 4'b0001);
      chk("s1_ready", cmd_ready, 4'b1110);
      gnt_man = 4'b0001;
      chk("s1_pre_valid", out_valid, 0);
      tick();
      chk("s1_first_beat_latency", out_valid, 1);
      run_burst(0, 16'h0100, 4, -1, 0);
      chk("s1_req_low", req, 0);
      chk("s1_ready_high", cmd_ready, 4'hF);
      gnt_man = '0;
      tick();

      load(1, 16'h0200, 4'd3);
      gnt_man = 4'b0010;
      run_burst(1, 16'h0200, 4, 2, 3);
      gnt_man = '0;
      tick();

      load(2, 16'hFFFE, 4'd3);
      gnt_man = 4'b0100;
      run_burst(2, 16'hFFFE, 4, -1, 0);
      tick();
      tick();
      tick();
      chk("stale_no_xfer", out_valid, 0);
      chk("stale_req", req, 0);
      chk("stale_err", gnt_err, 0);

      load(0, 16'h0300, 4'd0);
      load(1, 16'h0400, 4'd0);
      chk("ill_req", req, 4'b0011);
      gnt_man = 4'b0011;
      tick();
      chk("ill_err", gnt_err, 1);
      chk("ill_valid", out_valid, 1);
      chk("ill_id", out_id, 0);
      chk("ill_addr", out_addr, 16'h0300);
      chk("ill_last", out_last, 1);
      tick();
      gnt_man = 4'b0010;
      chk("ill_release", out_valid, 0);
      run_burst(1, 16'h0400, 1, -1, 0);
      chk("ill_err_sticky", gnt_err, 1);
      gnt_man = '0;

      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_err", gnt_err, 0);
      chk("rst2_ready", cmd_ready, 4'hF);
      use_arb = 1'b1;
      cmd_addr = {16'h3000, 16'h2000, 16'h1000, 16'h0000};
      cmd_len = {4'd1, 4'd1, 4'd1, 4'd1};
      cmd_valid = 4'hF;
      tick();
      cmd_valid = '0;
      chk("rot_req", req, 4'hF);
      run_burst(0, 16'h0000, 2, -1, 0);
      run_burst(1, 16'h1000, 2, -1, 0);
      run_burst(2, 16'h2000, 2, -1, 0);
      run_burst(3, 16'h3000, 2, -1, 0);
      chk("rot_req_done", req, 0);
      chk("rot_ready_done", cmd_ready, 4'hF);
      use_arb = 1'b0;
      tick();

      load(0, 16'h0500, 4'd7);
      gnt_man = 4'b0001;
      tick();
      chk("mid_beat0", out_addr, 16'h0500);
      tick();
      chk("mid_beat1", out_addr, 16'h0501);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_valid", out_valid, 0);
      chk("mid_req", req, 0);
      chk("mid_ready", cmd_ready, 4'hF);
      chk("mid_addr", out_addr, 0);
      load(0, 16'h0600, 4'd1);
      run_burst(0, 16'h0600, 2, -1, 0);
      gnt_man = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
